xbus_uart_tx: RTL

- Memory-mapped UART transmitter that responds to the core's xbus as a slave, alongside the RAM.
- Selected by one xbus_decoder chip-select line.
- Software writes bytes into an internal FIFO; an 8N1 serializer drains the FIFO onto a serial tx pin at a programmable bit period.
- A level interrupt signals that the transmitter is fully drained.

---
 rtl/xbus_uart_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/xbus_uart_tx.sv
// xbus slave UART transmitter: FIFO-fed 8N1 serializer
// with programmable bit period and drained-level interrupt.
module xbus_uart_tx #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RSTVAL = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        xbus_cs,
  input  logic        xbus_we,
  input  logic [3:0]  xbus_be,
  input  logic [31:0] xbus_addr,
  input  logic [31:0] xbus_wdata,
  output logic [31:0] xbus_rdata,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   div_q;
  logic          en_q, irqen_q;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          irq_q;

  logic          wr, rd;
  logic [1:0]    sel;
  logic          push_req, push_ok, pop;
  logic          empty, full, busy;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{xbus_addr[31:4], xbus_addr[1:0],
                         xbus_wdata[31:16], xbus_be[3:2]};

  assign wr  = xbus_cs & xbus_we;
  assign rd  = xbus_cs & ~xbus_we & rst;
  assign sel = xbus_addr[3:2];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign busy  = (state_q != S_IDLE);

  assign push_req = wr & (sel == 2'd0) & xbus_be[0];
  assign pop      = (state_q == S_IDLE) & en_q & ~empty;
  // a full FIFO still takes a push when a slot frees on the same edge
  assign push_ok  = push_req & (~full | pop);

  always_comb begin
    ovf_d = ovf_q;
    if (push_req && !push_ok)
      ovf_d = 1'b1;
    else if (wr && sel == 2'd1 && xbus_be[0] && xbus_wdata[3])
      ovf_d = 1'b0;
  end

  assign cnt_d = cnt_q + CW'(push_ok) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wptr_q] <= xbus_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= DIV_RSTVAL;
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
    end else if (wr) begin
      if (sel == 2'd2 && xbus_be[0])
        div_q[7:0] <= xbus_wdata[7:0];
      if (sel == 2'd2 && xbus_be[1])
        div_q[15:8] <= xbus_wdata[15:8];
      if (sel == 2'd3 && xbus_be[0]) begin
        en_q    <= xbus_wdata[0];
        irqen_q <= xbus_wdata[1];
      end
    end
  end

  // bit counter reloads from div_q at every bit boundary
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rptr_q];
          bcnt_d  = div_q;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == '0) begin
          bcnt_d  = div_q;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bcnt_q == '0) begin
          bcnt_d  = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7)
            state_d = S_STOP;
          else
            idx_d = idx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bcnt_q == '0)
          state_d = S_IDLE;
        else
          bcnt_d = bcnt_q - 16'd1;
      end
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      irq_q   <= irqen_q & empty & ~busy;
    end
  end

  assign tx  = tx_q;
  assign irq = irq_q;

  assign status = {16'h0, 8'(cnt_q), 4'h0,
                   ovf_q, busy, empty, full};

  always_comb begin
    xbus_rdata = '0;
    if (rd) begin
      unique case (sel)
        2'd0: xbus_rdata = '0;
        2'd1: xbus_rdata = status;
        2'd2: xbus_rdata = {16'h0, div_q};
        2'd3: xbus_rdata = {30'h0, irqen_q, en_q};
      endcase
    end
  end

endmodule
